// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: word geometry, opcode field and fetch state encoding.
package instruction_fetch_pkg;

   localparam int IF_ADDR_W = 8;
   localparam int IF_DATA_W = 32;
   localparam int OPC_W     = 6;

   localparam logic [OPC_W-1:0] IF_HALT_OPCODE = 6'b111111;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: shares the instruction memory port between loader and PC, tracks the one-cycle
// read latency and hands instruction+PC to decode over valid/ready with stall, redirect and halt.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                ADDR_W      = IF_ADDR_W,
   parameter int                DATA_W      = IF_DATA_W,
   parameter logic [ADDR_W-1:0] START_PC    = '0,
   parameter logic [OPC_W-1:0]  HALT_OPCODE = IF_HALT_OPCODE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              imem_mode,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   fetch_state_t      st;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pend_pc;
   logic              pend_valid;

   logic stall;
   logic transfer;
   logic halt_seen;

   assign stall     = pend_valid & ~if_ready;
   assign transfer  = if_valid & if_ready;
   assign halt_seen = transfer && (imem_rdata[DATA_W-1 -: OPC_W] == HALT_OPCODE);

   assign imem_mode  = run;
   assign imem_we    = ld_we & ~run;
   assign imem_wdata = ld_data;

   assign if_instr = imem_rdata;
   assign if_pc    = pend_pc;
   assign if_valid = (st == ST_RUN) & pend_valid & ~redirect;
   assign halted   = (st == ST_HALTED);

   // While stalled the pending address is re-read so imem_rdata keeps showing the held word.
   always_comb begin
      imem_addr = ld_addr;
      case (st)
         ST_RUN:    imem_addr = stall ? pend_pc : fetch_pc;
         ST_HALTED: imem_addr = fetch_pc;
         default:   imem_addr = ld_addr;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= ST_LOAD;
         fetch_pc   <= START_PC;
         pend_pc    <= '0;
         pend_valid <= 1'b0;
      end else begin
         case (st)
            ST_LOAD: begin
               pend_valid <= 1'b0;
               fetch_pc   <= START_PC;
               if (run) st <= ST_RUN;
            end
            ST_RUN: begin
               if (!run) begin
                  st         <= ST_LOAD;
                  pend_valid <= 1'b0;
                  fetch_pc   <= START_PC;
               end else if (redirect) begin
                  fetch_pc   <= redirect_pc;
                  pend_valid <= 1'b0;
               end else if (halt_seen) begin
                  // The word already in flight behind the halt is dropped.
                  st         <= ST_HALTED;
                  pend_valid <= 1'b0;
               end else if (!stall) begin
                  pend_pc    <= fetch_pc;
                  pend_valid <= 1'b1;
                  fetch_pc   <= fetch_pc + ADDR_W'(1);
               end
            end
            ST_HALTED: begin
               if (!run) begin
                  st       <= ST_LOAD;
                  fetch_pc <= START_PC;
               end
            end
            default: begin
               st         <= ST_LOAD;
               pend_valid <= 1'b0;
               fetch_pc   <= START_PC;
            end
         endcase
      end
   end

endmodule
